set_candidate_counter: RTL and testbench

- Counts lattice points of a fixed 8x8 grid (x,y each 1..8) that fall in a mode-selected set expression over up to three circles A, B and C.
- A host pulses a request carrying the three centres and radii and waits on a busy/valid handshake.
- The block returns an 8-bit point count.
- It is a standalone compute block with a one-request-at-a-time interface.

---
 rtl/set_candidate_counter.sv | 163 ++++++++++++++++
 tb/tb_set_candidate_counter.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/set_candidate_counter.sv
// set_candidate_counter: counts points of the 8x8 lattice (x,y in 1..8) lying in a
// mode-selected set expression over three circles A, B and C.
// One grid point is tested per cycle in x-major order. The result is returned
// 65 cycles after the request is accepted.
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   en        request strobe; accepted only while busy=0
//   central   {x1,y1,x2,y2,x3,y3}, 4 bits each (circles A, B, C)
//   radius    {r1,r2,r3}, 4 bits each
//   mode      00=A, 01=A|B, 10=A^B, 11=in exactly two circles
//   busy      high while a request is in progress
//   valid     one-cycle pulse when candidate is updated
//   candidate point count 0..64, held until the next result
module set_candidate_counter (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [23:0] central,
   input  logic [11:0] radius,
   input  logic [1:0]  mode,
   output logic        busy,
   output logic        valid,
   output logic [7:0]  candidate
);

   localparam int unsigned CW = 4;   // coordinate / radius width
   localparam int unsigned IW = 6;   // grid point index width (64 points)
   localparam int unsigned AW = 8;   // accumulator width
   localparam int unsigned SW = 10;  // squared-distance width

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e        state_q,   state_d;
   logic [23:0]   central_q, central_d;
   logic [11:0]   radius_q,  radius_d;
   logic [1:0]    mode_q,    mode_d;
   logic [IW-1:0] idx_q,     idx_d;
   logic [AW-1:0] acc_q,     acc_d;
   logic [AW-1:0] cand_q,    cand_d;
   logic          busy_q,    busy_d;
   logic          valid_q,   valid_d;

   logic [CW-1:0] px_c, py_c;
   logic          in_a_c, in_b_c, in_c_c;
   logic          hit_c;

   // Inclusive disc test; differences are signed and squared as magnitudes.
   function automatic logic in_circle(input logic [CW-1:0] x,  input logic [CW-1:0] y,
                                      input logic [CW-1:0] xc, input logic [CW-1:0] yc,
                                      input logic [CW-1:0] r);
      logic signed [5:0] dx, dy;
      logic [5:0]        ax, ay;
      logic [SW-1:0]     ax_w, ay_w, r_w, d2, r2;
      dx   = $signed({2'b00, x}) - $signed({2'b00, xc});
      dy   = $signed({2'b00, y}) - $signed({2'b00, yc});
      ax   = dx[5] ? 6'(-dx) : 6'(dx);
      ay   = dy[5] ? 6'(-dy) : 6'(dy);
      ax_w = SW'(ax);
      ay_w = SW'(ay);
      r_w  = SW'(r);
      d2   = ax_w * ax_w + ay_w * ay_w;
      r2   = r_w * r_w;
      return d2 <= r2;
   endfunction

   // Current grid point from the scan index: x is the outer (upper) field.
   assign px_c = CW'(idx_q[5:3]) + CW'(1);
   assign py_c = CW'(idx_q[2:0]) + CW'(1);

   assign in_a_c = in_circle(px_c, py_c, central_q[23:20], central_q[19:16], radius_q[11:8]);
   assign in_b_c = in_circle(px_c, py_c, central_q[15:12], central_q[11:8],  radius_q[7:4]);
   assign in_c_c = in_circle(px_c, py_c, central_q[7:4],   central_q[3:0],   radius_q[3:0]);

   // Set expression selected by the latched mode.
   always_comb begin
      hit_c = 1'b0;
      case (mode_q)
         2'b00:   hit_c = in_a_c;
         2'b01:   hit_c = in_a_c | in_b_c;
         2'b10:   hit_c = in_a_c ^ in_b_c;
         default: hit_c = ((in_a_c & in_b_c) | (in_b_c & in_c_c) | (in_a_c & in_c_c))
                          & ~(in_a_c & in_b_c & in_c_c);
      endcase
   end

   // Next-state and output logic.
   always_comb begin
      state_d   = state_q;
      central_d = central_q;
      radius_d  = radius_q;
      mode_d    = mode_q;
      idx_d     = idx_q;
      acc_d     = acc_q;
      cand_d    = cand_q;
      busy_d    = busy_q;
      valid_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (en) begin
               central_d = central;
               radius_d  = radius;
               mode_d    = mode;
               idx_d     = '0;
               acc_d     = '0;
               busy_d    = 1'b1;
               state_d   = CALC;
            end
         end
         CALC: begin
            acc_d = acc_q + AW'(hit_c);
            idx_d = idx_q + IW'(1);
            if (idx_q == IW'(63)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            cand_d  = acc_q;
            valid_d = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // State registers; reset aborts any request in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         central_q <= '0;
         radius_q  <= '0;
         mode_q    <= '0;
         idx_q     <= '0;
         acc_q     <= '0;
         cand_q    <= '0;
         busy_q    <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         central_q <= central_d;
         radius_q  <= radius_d;
         mode_q    <= mode_d;
         idx_q     <= idx_d;
         acc_q     <= acc_d;
         cand_q    <= cand_d;
         busy_q    <= busy_d;
         valid_q   <= valid_d;
      end
   end

   assign busy      = busy_q;
   assign valid     = valid_q;
   assign candidate = cand_q;

endmodule

// File: tb/tb_set_candidate_counter.sv
// Directed bench for set_candidate_counter: single discs, clipping, union/xor,
// exactly-two, handshake timing, back-to-back requests and mid-operation reset.
module tb_set_candidate_counter;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [23:0] central;
   logic [11:0] radius;
   logic [1:0]  mode;
   logic        busy;
   logic        valid;
   logic [7:0]  candidate;

   int checks = 0;
   int errors = 0;
   logic [7:0] last_cand;

   localparam int NV = 14;
   logic [23:0] tc [NV] = '{24'h440000, 24'h440000, 24'h440000, 24'h440000,
                           24'h110000, 24'h000000, 24'h445400, 24'h445400,
                           24'h227700, 24'h227700, 24'h445488, 24'h445444,
                           24'h880000, 24'h940000};
   logic [11:0] tr [NV] = '{12'h000, 12'h100, 12'h200, 12'hF00,
                           12'h100, 12'h100, 12'h110, 12'h110,
                           12'h110, 12'h110, 12'h110, 12'h110,
                           12'h000, 12'h100};
   logic [1:0]  tm [NV] = '{2'd0, 2'd0, 2'd0, 2'd0,
                           2'd0, 2'd0, 2'd1, 2'd2,
                           2'd1, 2'd2, 2'd3, 2'd3,
                           2'd0, 2'd0};
   int          te [NV] = '{1, 5, 13, 64,
                           3, 0, 8, 6,
                           10, 10, 2, 1,
                           1, 1};

   set_candidate_counter dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .central   (central),
      .radius    (radius),
      .mode      (mode),
      .busy      (busy),
      .valid     (valid),
      .candidate (candidate)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Called just after a negedge; issues one request and waits for its result.
   task automatic run_req(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m,
                          input int exp, input bit noise);
      int n;
      bit busy_ok;
      central = c;
      radius  = r;
      mode    = m;
      en      = 1'b1;
      @(negedge clk);
      en = 1'b0;
      if (noise) begin
         central = 24'hFFFFFF;
         radius  = 12'hFFF;
         mode    = 2'b11;
      end
      check("busy_after_accept", 32'(busy), 32'd1);
      check("valid_one_cycle", 32'(valid), 32'd0);
      check("cand_hold", 32'(candidate), 32'(last_cand));
      n = 0;
      busy_ok = 1'b1;
      while (!valid && n < 200) begin
         @(negedge clk);
         n++;
         en = noise && (n == 10 || n == 40);
         if (!valid && !busy) busy_ok = 1'b0;
      end
      en = 1'b0;
      check("latency", 32'(n), 32'd65);
      check("busy_held", 32'(busy_ok), 32'd1);
      check("busy_at_valid", 32'(busy), 32'd0);
      check("candidate", 32'(candidate), 32'(exp));
      last_cand = 8'(exp);
   endtask

   initial begin
      rst = 1'b0;
      en = 1'b0;
      central = '0;
      radius = '0;
      mode = '0;
      last_cand = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_cand", 32'(candidate), 32'd0);
      rst = 1'b1;
      @(negedge clk);

      for (int i = 0; i < NV; i++) run_req(tc[i], tr[i], tm[i], te[i], 1'b0);

      // en pulses while busy and inputs changing after acceptance
      run_req(24'h445400, 12'h110, 2'd2, 6, 1'b1);
      run_req(24'h445444, 12'h110, 2'd3, 1, 1'b1);

      // back-to-back requests, next accept on the edge after valid
      for (int i = 0; i < 64; i++) run_req(tc[i % NV], tr[i % NV], tm[i % NV], te[i % NV], 1'b0);

      // mid-operation reset
      central = 24'h440000;
      radius = 12'h200;
      mode = 2'd0;
      en = 1'b1;
      @(negedge clk);
      en = 1'b0;
      repeat (30) @(negedge clk);
      rst = 1'b0;
      #1;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_valid", 32'(valid), 32'd0);
      check("midrst_cand", 32'(candidate), 32'd0);
      last_cand = '0;
      @(negedge clk);
      rst = 1'b1;
      repeat (70) begin
         @(negedge clk);
         if (valid) check("midrst_no_valid", 32'(valid), 32'd0);
      end
      check("midrst_idle", 32'(busy), 32'd0);
      run_req(24'h440000, 12'h100, 2'd0, 5, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
